// File: rtl/fft32_cmul_pipe_if.sv
// Handshake bundle for the fft32 complex multiplier: one sample stream in, one result stream out.
// A transfer happens on a rising edge where valid and ready are both 1. A producer holds
// valid and its data steady until that edge, and valid never depends on ready.
interface fft32_cmul_pipe_if #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_conj;
    logic signed [DIN0_WIDTH-1:0] a_re;
    logic signed [DIN0_WIDTH-1:0] a_im;
    logic signed [DIN1_WIDTH-1:0] w_re;
    logic signed [DIN1_WIDTH-1:0] w_im;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] out_re;
    logic signed [DOUT_WIDTH-1:0] out_im;
    logic                         out_sat;

    modport master (
        output in_valid, in_conj, a_re, a_im, w_re, w_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sat
    );

    modport slave (
        input  in_valid, in_conj, a_re, a_im, w_re, w_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sat
    );
endinterface

// File: rtl/fft32_cmul_pipe.sv
// Pipelined signed complex multiply a*w (or a*conj(w)) with rounding shift and saturation.
// Stage 1 registers the four partial products, middle stages delay them, the last stage holds the result.
module fft32_cmul_pipe #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int FRAC_SHIFT = 14,
    parameter int NUM_STAGE  = 3,
    parameter int ROUND_MODE = 1
) (
    input logic               clk,
    input logic               reset,
    fft32_cmul_pipe_if.slave  bus
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int P  = PW + 1;
    localparam int Q  = P + 1;
    localparam int D  = NUM_STAGE - 1;
    localparam int L  = D - 1;

    localparam logic signed [Q-1:0] BIAS = (ROUND_MODE != 0) ? (Q'(1) << (FRAC_SHIFT - 1)) : '0;
    localparam logic signed [Q-1:0] MAXV = {{(Q-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [Q-1:0] MINV = {{(Q-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic advance;
    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    logic signed [PW-1:0] a_re_x, a_im_x, w_re_x, w_im_x;
    assign a_re_x = PW'(bus.a_re);
    assign a_im_x = PW'(bus.a_im);
    assign w_re_x = PW'(bus.w_re);
    assign w_im_x = PW'(bus.w_im);

    logic                 v_q  [D];
    logic                 c_q  [D];
    logic signed [PW-1:0] rr_q [D];
    logic signed [PW-1:0] ii_q [D];
    logic signed [PW-1:0] ri_q [D];
    logic signed [PW-1:0] ir_q [D];

    logic signed [P-1:0] sum_re, sum_im;

    always_comb begin
        sum_re = '0;
        sum_im = '0;
        if (c_q[L]) begin
            sum_re = P'(rr_q[L]) + P'(ii_q[L]);
            sum_im = P'(ir_q[L]) - P'(ri_q[L]);
        end else begin
            sum_re = P'(rr_q[L]) - P'(ii_q[L]);
            sum_im = P'(ri_q[L]) + P'(ir_q[L]);
        end
    end

    // Bias is added one bit wider than the sum so the rounding carry can never wrap.
    function automatic logic [DOUT_WIDTH:0] scale_sat(input logic signed [P-1:0] s);
        logic signed [Q-1:0] t;
        t = (Q'(s) + BIAS) >>> FRAC_SHIFT;
        if (t > MAXV)
            return {1'b1, MAXV[DOUT_WIDTH-1:0]};
        else if (t < MINV)
            return {1'b1, MINV[DOUT_WIDTH-1:0]};
        else
            return {1'b0, t[DOUT_WIDTH-1:0]};
    endfunction

    logic [DOUT_WIDTH:0] res_re, res_im;
    assign res_re = scale_sat(sum_re);
    assign res_im = scale_sat(sum_im);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                v_q[i]  <= 1'b0;
                c_q[i]  <= 1'b0;
                rr_q[i] <= '0;
                ii_q[i] <= '0;
                ri_q[i] <= '0;
                ir_q[i] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_sat   <= 1'b0;
        end else if (advance) begin
            v_q[0]  <= bus.in_valid;
            c_q[0]  <= bus.in_conj;
            rr_q[0] <= a_re_x * w_re_x;
            ii_q[0] <= a_im_x * w_im_x;
            ri_q[0] <= a_re_x * w_im_x;
            ir_q[0] <= a_im_x * w_re_x;
            for (int i = 1; i < D; i++) begin
                v_q[i]  <= v_q[i-1];
                c_q[i]  <= c_q[i-1];
                rr_q[i] <= rr_q[i-1];
                ii_q[i] <= ii_q[i-1];
                ri_q[i] <= ri_q[i-1];
                ir_q[i] <= ir_q[i-1];
            end
            bus.out_valid <= v_q[L];
            bus.out_re    <= res_re[DOUT_WIDTH-1:0];
            bus.out_im    <= res_im[DOUT_WIDTH-1:0];
            bus.out_sat   <= res_re[DOUT_WIDTH] | res_im[DOUT_WIDTH];
        end
    end
endmodule

// File: tb/tb_fft32_cmul_pipe.sv
// Bench for fft32_cmul_pipe: directed cases plus random streams under back-pressure,
// checked against an integer reference model of the complex multiply.
module tb_fft32_cmul_pipe;
    localparam int DIN0_WIDTH = 14;
    localparam int DIN1_WIDTH = 16;
    localparam int DOUT_WIDTH = 16;
    localparam int FRAC_SHIFT = 14;
    localparam int NUM_STAGE  = 3;
    localparam int ROUND_MODE = 1;
    localparam int EW         = 2 * DOUT_WIDTH + 1;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fft32_cmul_pipe_if #(
        .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
    ) bus ();

    fft32_cmul_pipe #(
        .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT), .NUM_STAGE(NUM_STAGE), .ROUND_MODE(ROUND_MODE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    bit            prev_stall;
    logic [EW:0]   prev_out;
    logic          s_valid, s_ready, s_sat, s_acc;
    logic signed [DOUT_WIDTH-1:0] s_re, s_im;
    int            n_pop = 0;
    int            n_acc = 0;

    function automatic logic [EW-1:0] model(input longint ar, input longint ai,
                                            input longint wr, input longint wi, input bit cj);
        longint re, im, b, maxo, mino;
        bit     sat;
        maxo = (longint'(1) <<< (DOUT_WIDTH - 1)) - 1;
        mino = -(longint'(1) <<< (DOUT_WIDTH - 1));
        if (cj) begin
            re = ar * wr + ai * wi;
            im = ai * wr - ar * wi;
        end else begin
            re = ar * wr - ai * wi;
            im = ar * wi + ai * wr;
        end
        b  = (ROUND_MODE != 0) ? (longint'(1) <<< (FRAC_SHIFT - 1)) : 0;
        re = (re + b) >>> FRAC_SHIFT;
        im = (im + b) >>> FRAC_SHIFT;
        sat = 1'b0;
        if (re > maxo) begin re = maxo; sat = 1'b1; end
        if (re < mino) begin re = mino; sat = 1'b1; end
        if (im > maxo) begin im = maxo; sat = 1'b1; end
        if (im < mino) begin im = mino; sat = 1'b1; end
        return {sat, re[DOUT_WIDTH-1:0], im[DOUT_WIDTH-1:0]};
    endfunction

    // One clock cycle: sample mid-cycle, score handshakes, then wait for the next falling edge.
    task automatic tick();
        logic [EW-1:0] got, e;
        #2;
        s_acc = 1'b0;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule: got %0b with out_valid=%0b out_ready=%0b",
                         bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (prev_stall) begin
                checks++;
                if ({bus.out_valid, bus.out_sat, bus.out_re, bus.out_im} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h",
                             {bus.out_valid, bus.out_sat, bus.out_re, bus.out_im}, prev_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                got = {bus.out_sat, bus.out_re, bus.out_im};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h with no sample outstanding", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got sat=%0b re=%0d im=%0d required sat=%0b re=%0d im=%0d",
                                 got[EW-1], $signed(got[2*DOUT_WIDTH-1:DOUT_WIDTH]),
                                 $signed(got[DOUT_WIDTH-1:0]), e[EW-1],
                                 $signed(e[2*DOUT_WIDTH-1:DOUT_WIDTH]), $signed(e[DOUT_WIDTH-1:0]));
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
                s_acc = 1'b1;
                exp_q.push_back(model(longint'(bus.a_re), longint'(bus.a_im),
                                      longint'(bus.w_re), longint'(bus.w_im), bus.in_conj));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.out_sat, bus.out_re, bus.out_im};
        end
        s_valid = bus.out_valid;
        s_ready = bus.in_ready;
        s_sat   = bus.out_sat;
        s_re    = bus.out_re;
        s_im    = bus.out_im;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_sample();
        bus.in_conj = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            bus.a_re = {1'b1, {(DIN0_WIDTH-1){1'b0}}};
            bus.a_im = $urandom_range(0, 1) ? {1'b1, {(DIN0_WIDTH-1){1'b0}}} : {1'b0, {(DIN0_WIDTH-1){1'b1}}};
            bus.w_re = {1'b1, {(DIN1_WIDTH-1){1'b0}}};
            bus.w_im = $urandom_range(0, 1) ? {1'b1, {(DIN1_WIDTH-1){1'b0}}} : {1'b0, {(DIN1_WIDTH-1){1'b1}}};
        end else begin
            bus.a_re = DIN0_WIDTH'($urandom);
            bus.a_im = DIN0_WIDTH'($urandom);
            bus.w_re = DIN1_WIDTH'($urandom);
            bus.w_im = DIN1_WIDTH'($urandom);
        end
    endtask

    task automatic run_one(input logic signed [DIN0_WIDTH-1:0] ar, input logic signed [DIN0_WIDTH-1:0] ai,
                           input logic signed [DIN1_WIDTH-1:0] wr, input logic signed [DIN1_WIDTH-1:0] wi,
                           input logic cj,
                           output logic signed [DOUT_WIDTH-1:0] re, output logic signed [DOUT_WIDTH-1:0] im,
                           output logic sat, output int lat);
        bus.a_re = ar; bus.a_im = ai; bus.w_re = wr; bus.w_im = wi; bus.in_conj = cj;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_valid && lat < 20);
        re = s_re; im = s_im; sat = s_sat;
    endtask

    task automatic drain(input string name);
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < NUM_STAGE + 2; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d samples still outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_conj = 1'b0;
        bus.a_re = '0; bus.a_im = '0; bus.w_re = '0; bus.w_im = '0;
        @(negedge clk);
        tick();
        tick();
        checks++;
        if ({s_valid, s_sat, s_re, s_im} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b sat=%0b re=%0d im=%0d required all 0",
                     s_valid, s_sat, s_re, s_im);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", s_ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got in_ready=%0b out_valid=%0b required 1/0", s_ready, s_valid);
        end
    endtask

    task automatic test_identity();
        logic signed [DOUT_WIDTH-1:0] re, im;
        logic sat;
        int lat;
        run_one(14'sd100, -14'sd200, 16'sd16384, 16'sd0, 1'b0, re, im, sat, lat);
        checks++;
        if (lat !== NUM_STAGE) begin
            errors++;
            $display("FAIL identity_latency: got %0d required %0d", lat, NUM_STAGE);
        end
        checks++;
        if (re !== 16'sd100 || im !== -16'sd200 || sat !== 1'b0) begin
            errors++;
            $display("FAIL identity_value: got (%0d,%0d) sat=%0b required (100,-200) sat=0", re, im, sat);
        end
    endtask

    task automatic test_rotation_conj();
        logic signed [DOUT_WIDTH-1:0] re, im;
        logic sat;
        int lat;
        run_one(14'sd100, -14'sd200, 16'sd0, 16'sd16384, 1'b0, re, im, sat, lat);
        checks++;
        if (re !== 16'sd200 || im !== 16'sd100 || sat !== 1'b0) begin
            errors++;
            $display("FAIL rotation: got (%0d,%0d) sat=%0b required (200,100) sat=0", re, im, sat);
        end
        run_one(14'sd100, -14'sd200, 16'sd0, 16'sd16384, 1'b1, re, im, sat, lat);
        checks++;
        if (re !== -16'sd200 || im !== -16'sd100 || sat !== 1'b0) begin
            errors++;
            $display("FAIL conj: got (%0d,%0d) sat=%0b required (-200,-100) sat=0", re, im, sat);
        end
    endtask

    task automatic test_rounding();
        logic signed [DOUT_WIDTH-1:0] re, im, e_pos, e_neg;
        logic sat;
        int lat;
        e_pos = (ROUND_MODE != 0) ? 16'sd1 : 16'sd0;
        e_neg = (ROUND_MODE != 0) ? 16'sd0 : -16'sd1;
        run_one(14'sd1, 14'sd0, 16'sd8192, 16'sd0, 1'b0, re, im, sat, lat);
        checks++;
        if (re !== e_pos || im !== 16'sd0) begin
            errors++;
            $display("FAIL round_pos_half: got (%0d,%0d) required (%0d,0)", re, im, e_pos);
        end
        run_one(-14'sd1, 14'sd0, 16'sd8192, 16'sd0, 1'b0, re, im, sat, lat);
        checks++;
        if (re !== e_neg || im !== 16'sd0) begin
            errors++;
            $display("FAIL round_neg_half: got (%0d,%0d) required (%0d,0)", re, im, e_neg);
        end
    endtask

    task automatic test_saturation();
        logic signed [DOUT_WIDTH-1:0] re, im;
        logic sat;
        int lat;
        run_one(14'h2000, 14'h2000, 16'h8000, 16'h8000, 1'b0, re, im, sat, lat);
        checks++;
        if (re !== 16'sd0 || im !== 16'sd32767 || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp: got (%0d,%0d) sat=%0b required (0,32767) sat=1", re, im, sat);
        end
        run_one(14'sd1, 14'sd1, 16'sd16384, 16'sd0, 1'b0, re, im, sat, lat);
        checks++;
        if (re !== 16'sd1 || im !== 16'sd1 || sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_not_sticky: got (%0d,%0d) sat=%0b required (1,1) sat=0", re, im, sat);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_sample();
            bus.in_valid = 1'b1;
            tick();
            checks++;
            if (s_acc !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept: sample %0d not accepted, in_ready=%0b", i, s_ready);
            end
            if (i >= NUM_STAGE) begin
                checks++;
                if (s_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_throughput: cycle %0d out_valid=%0b required 1", i, s_valid);
                end
            end
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int sent, acc0, pop0, n;
        acc0 = n_acc;
        pop0 = n_pop;
        sent = 0;
        n = 0;
        rand_sample();
        bus.in_valid = 1'b1;
        while (sent < 20 && n < 400) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (s_acc) begin
                sent++;
                rand_sample();
            end
        end
        drain("bp");
        checks++;
        if ((n_acc - acc0) !== 20 || (n_pop - pop0) !== 20) begin
            errors++;
            $display("FAIL bp_count: accepted %0d emitted %0d required 20/20", n_acc - acc0, n_pop - pop0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_sample();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain("rand");
    endtask

    task automatic test_reset_midstream();
        logic signed [DOUT_WIDTH-1:0] re, im;
        logic sat;
        int lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_sample();
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flush: got out_valid=%0b required 0", s_valid);
        end
        for (int i = 0; i < NUM_STAGE + 2; i++) tick();
        run_one(14'sd300, 14'sd50, 16'sd16384, 16'sd0, 1'b0, re, im, sat, lat);
        checks++;
        if (lat !== NUM_STAGE || re !== 16'sd300 || im !== 16'sd50 || sat !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d (%0d,%0d) sat=%0b required lat=%0d (300,50) sat=0",
                     lat, re, im, sat, NUM_STAGE);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_identity();
        test_rotation_conj();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        drain("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
